// File: rtl/wb_j1_arbiter.sv
// wb_j1_arbiter: round-robin Wishbone arbiter sharing one slave among four j1 CPUs.
// Define ARB_TIMEOUT_EN to add an ack timeout that force-acks the owner and sets err_o.
module wb_j1_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   m_cyc_i,
   input  logic [3:0]   m_we_i,
   input  logic [127:0] m_adr_i,
   input  logic [127:0] m_dat_i,
   output logic [31:0]  m_dat_o,
   output logic [3:0]   m_ack_o,
   output logic         s_cyc_o,
   output logic         s_we_o,
   output logic [31:0]  s_adr_o,
   output logic [31:0]  s_dat_o,
   input  logic [31:0]  s_dat_i,
   input  logic         s_ack_i,
   output logic [1:0]   grant_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   // This revision is wired for exactly four masters and an 8-bit wait counter.
   if (NUM_MASTERS != 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_bad
      $error("wb_j1_arbiter: unsupported NUM_MASTERS/TIMEOUT");
   end

   logic [1:0] state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] last_q, last_d;
   logic [1:0] pick;
   logic [1:0] idx;
   logic       found;
   logic       in_bus;
   logic       own_cyc;
   logic       tmo;

   assign in_bus  = (state_q == ST_BUS);
   assign own_cyc = m_cyc_i[grant_q];
   assign grant_o = grant_q;
   assign busy_o  = in_bus;

   // Round-robin search starting one past the last owner.
   always_comb begin
      pick  = last_q;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!found && m_cyc_i[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   // Fires on the TIMEOUT-th consecutive unacknowledged cycle of a live request.
   assign tmo   = in_bus & own_cyc & ~s_ack_i & (cnt_q == TO_LAST);
   assign err_o = err_q;

   // Wait counter restarts with each grant; error flag is sticky until reset.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q | tmo;
      if (state_q == ST_IDLE && found) begin
         cnt_d = '0;
      end else if (in_bus && !s_ack_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Timeout state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign tmo   = 1'b0;
   assign err_o = 1'b0;
`endif

   // Owner's request steered to the slave; slave response routed to the owner.
   always_comb begin
      s_cyc_o = in_bus & own_cyc;
      s_we_o  = in_bus & m_we_i[grant_q];
      s_adr_o = '0;
      s_dat_o = '0;
      m_ack_o = '0;
      m_dat_o = '0;
      if (in_bus) begin
         s_adr_o = m_adr_i[{grant_q, 5'd0} +: 32];
         s_dat_o = m_dat_i[{grant_q, 5'd0} +: 32];
         if (s_ack_i || tmo) begin
            m_ack_o[grant_q] = 1'b1;
         end
         if (!tmo) begin
            m_dat_o = s_dat_i;
         end
      end
   end

   // Arbitration FSM: grant, wait for ack or abort, one-cycle release.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            if (s_ack_i || tmo) begin
               state_d = ST_REL;
               last_d  = grant_q;
            end else if (!own_cyc) begin
               state_d = ST_IDLE;
               last_d  = grant_q;
            end
         end
         ST_REL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM registers; last owner resets to 3 so master 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 2'd0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_wb_j1_arbiter.sv
// tb_wb_j1_arbiter: directed stimulus with a per-cycle reference model
// of the arbiter plus hand-computed literal checks.
module tb_wb_j1_arbiter;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   m_cyc_i, m_we_i;
   logic [127:0] m_adr_i, m_dat_i;
   logic [31:0]  m_dat_o;
   logic [3:0]   m_ack_o;
   logic         s_cyc_o, s_we_o;
   logic [31:0]  s_adr_o, s_dat_o, s_dat_i;
   logic         s_ack_i;
   logic [1:0]   grant_o;
   logic         busy_o, err_o;

   always #5 clk = ~clk;

   wb_j1_arbiter #(.NUM_MASTERS(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
   );

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Reference model: phase 0 = idle, 1 = bus owned, 2 = release.
   int ph = 0;
   int own = 0;
   int last = 3;
   int cnt = 0;
   bit merr = 1'b0;

   function automatic bit fire();
`ifdef ARB_TIMEOUT_EN
      return (ph == 1) && m_cyc_i[own] && !s_ack_i && (cnt == TO - 1);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ph = 0; own = 0; last = 3; cnt = 0; merr = 1'b0;
      end else begin
         case (ph)
            0: if (m_cyc_i != 4'b0000) begin
                  for (int k = 1; k <= 4; k++) begin
                     if (m_cyc_i[(last + k) % 4]) begin
                        own = (last + k) % 4;
                        break;
                     end
                  end
                  ph = 1;
                  cnt = 0;
               end
            1: if (s_ack_i) begin
                  ph = 2; last = own;
               end else if (!m_cyc_i[own]) begin
                  ph = 0; last = own;
               end else if (fire()) begin
                  ph = 2; last = own; merr = 1'b1;
               end else begin
                  cnt++;
               end
            default: ph = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [105:0] got, exp;
      bit bus, f;
      logic [3:0] eack;
      if (chk_en) begin
         bus = (ph == 1);
         f = fire();
         eack = (bus && (s_ack_i || f)) ? 4'(1 << own) : 4'b0000;
         exp = {bus && m_cyc_i[own], bus && m_we_i[own],
                bus ? m_adr_i[own*32 +: 32] : 32'h0,
                bus ? m_dat_i[own*32 +: 32] : 32'h0,
                eack,
                (bus && !f) ? s_dat_i : 32'h0,
                2'(own), bus, merr};
         got = {s_cyc_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_dat_o,
                grant_o, busy_o, err_o};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, got, exp);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy();
      int n = 0;
      @(negedge clk);
      while (!busy_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (!busy_o) begin
         miscompares++;
         $display("FAIL wait_busy t=%0t got=0 exp=1", $time);
      end
   endtask

   task automatic idle_gap();
      tick();
      m_cyc_i = '0; m_we_i = '0; s_ack_i = 1'b0; s_dat_i = '0;
      tick();
      tick();
   endtask

   task automatic set_m(input int k, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      m_we_i[k] = we;
      m_adr_i[k*32 +: 32] = a;
      m_dat_i[k*32 +: 32] = d;
   endtask

   logic [3:0] tc[16] = '{4'b1010, 4'b1010, 4'b1111, 4'b1111, 4'b0110,
                          4'b0110, 4'b0001, 4'b1000, 4'b1000, 4'b0101,
                          4'b0101, 4'b0101, 4'b1100, 4'b0000, 4'b0011,
                          4'b0011};
   logic       ta[16] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 1, 1};
   int g_exp[5] = '{0, 1, 2, 3, 0};

   initial begin
      #200000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; m_cyc_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0;
      for (int k = 0; k < 4; k++) set_m(k, 1'b0, 32'h1000 * (k + 1), 32'h11 * (k + 1));
      tick();
      chk_en = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_scyc", 32'(s_cyc_o), 32'd0);

      // Single read by master 0, slave acks in the first bus cycle.
      tick();
      rst = 1'b0;
      set_m(0, 1'b0, 32'h100, 32'h0);
      s_ack_i = 1'b1; s_dat_i = 32'h1234; m_cyc_i = 4'b0001;
      wait_busy();
      chk("t1_ack", 32'(m_ack_o), 32'h1);
      chk("t1_dat", m_dat_o, 32'h1234);
      chk("t1_grant", 32'(grant_o), 32'd0);
      chk("t1_adr", s_adr_o, 32'h100);
      idle_gap();

      // All four request continuously with instant acks: rotating grants.
      rst = 1'b1;
      tick();
      rst = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h55; m_cyc_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_busy();
         chk("t2_grant", 32'(grant_o), 32'(g_exp[i]));
      end
      idle_gap();

      // Master 2 write, ack after two wait cycles.
      set_m(2, 1'b1, 32'h40, 32'hA5A5A5A5);
      m_cyc_i = 4'b0100;
      wait_busy();
      chk("t3_we", 32'(s_we_o), 32'd1);
      chk("t3_adr", s_adr_o, 32'h40);
      chk("t3_dat", s_dat_o, 32'hA5A5A5A5);
      chk("t3_noack", 32'(m_ack_o), 32'h0);
      tick();
      @(negedge clk);
      chk("t3_hold", 32'(s_cyc_o), 32'd1);
      tick();
      s_ack_i = 1'b1;
      @(negedge clk);
      chk("t3_ack", 32'(m_ack_o), 32'h4);
      idle_gap();
      m_we_i = '0;

      // Master 1 aborts; master 2 gets the next grant.
      m_cyc_i = 4'b0010;
      wait_busy();
      chk("t4_grant1", 32'(grant_o), 32'd1);
      tick();
      m_cyc_i = 4'b0100;
      @(negedge clk);
      chk("t4_scyc", 32'(s_cyc_o), 32'd0);
      chk("t4_noack", 32'(m_ack_o), 32'h0);
      tick();
      @(negedge clk);
      chk("t4_idle", 32'(busy_o), 32'd0);
      wait_busy();
      chk("t4_grant2", 32'(grant_o), 32'd2);
      tick();
      s_ack_i = 1'b1;
      idle_gap();

      // Reset during a bus cycle.
      m_cyc_i = 4'b1000;
      wait_busy();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_pre", 32'(busy_o), 32'd1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_busy", 32'(busy_o), 32'd0);
      chk("t5_scyc", 32'(s_cyc_o), 32'd0);
      chk("t5_grant", 32'(grant_o), 32'd0);
      chk("t5_ack", 32'(m_ack_o), 32'h0);
      idle_gap();

      // Slave never acks.
      s_dat_i = 32'hDEADBEEF;
      m_cyc_i = 4'b0001;
      wait_busy();
`ifdef ARB_TIMEOUT_EN
      chk("t6_c1", 32'(m_ack_o), 32'h0);
      tick(); tick(); tick();
      @(negedge clk);
      chk("t6_ack", 32'(m_ack_o), 32'h1);
      chk("t6_dat", m_dat_o, 32'h0);
      tick();
      @(negedge clk);
      chk("t6_err", 32'(err_o), 32'd1);
      idle_gap();
      @(negedge clk);
      chk("t6_sticky", 32'(err_o), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_clr", 32'(err_o), 32'd0);
`else
      repeat (8) tick();
      @(negedge clk);
      chk("t6_wait", 32'(busy_o), 32'd1);
      chk("t6_noack", 32'(m_ack_o), 32'h0);
      chk("t6_noerr", 32'(err_o), 32'd0);
      idle_gap();
`endif

      // Mixed contention patterns checked by the model each cycle.
      s_dat_i = 32'h600D;
      for (int i = 0; i < 16; i++) begin
         m_cyc_i = tc[i];
         s_ack_i = ta[i];
         tick();
      end
      idle_gap();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_j1_arbiter.md
WB_J1_ARBITER -- requirements
Module: wb_j1_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of j1 CPU bus masters (fixed 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles a grant may wait for slave ack (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port m_cyc_i  input  4  per-master bus request; bit k from CPU k.
REQ-006 SHALL have port m_we_i  input  4  per-master write enable.
REQ-007 SHALL have port m_adr_i  input  128  master k address at bits [32k+31:32k].
REQ-008 SHALL have port m_dat_i  input  128  master k write data at bits [32k+31:32k].
REQ-009 SHALL have port m_dat_o  output  32  read data broadcast to all masters.
REQ-010 SHALL have port m_ack_o  output  4  per-master acknowledge.
REQ-011 SHALL have ports s_cyc_o, s_we_o  output  1 each; s_adr_o, s_dat_o  output  32 each: shared slave request.
REQ-012 SHALL have ports s_dat_i  input  32, s_ack_i  input  1: shared slave response.
REQ-013 SHALL have port grant_o  output  2  index of current owner.
REQ-014 SHALL have port busy_o  output  1  high while state is BUS.
REQ-015 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-016 FSM states: IDLE, BUS, RELEASE.
REQ-017 IDLE: if any m_cyc_i bit set, SHALL select owner by round-robin starting from (last_owner+1) mod 4, register it into grant_o, go to BUS next cycle; else stay IDLE.
REQ-018 BUS: s_cyc_o = m_cyc_i[owner]; s_we_o, s_adr_o, s_dat_o SHALL combinationally mux owner's signals; all zero outside BUS.
REQ-019 BUS: m_ack_o[owner] = s_ack_i combinationally, other bits 0; m_dat_o = s_dat_i during BUS, else 0.
REQ-020 BUS with s_ack_i=1 SHALL go to RELEASE; last_owner <= owner.
REQ-021 BUS with m_cyc_i[owner]=0 and s_ack_i=0 (master abort) SHALL go to IDLE without ack; last_owner <= owner.
REQ-022 RELEASE SHALL last exactly one cycle, drive no slave request, then go to IDLE.
REQ-023 Grant latency: request sampled in IDLE at edge t SHALL see s_cyc_o high in cycle t+1; minimum 3 cycles per transaction (IDLE, BUS, RELEASE).
REQ-024 Simultaneous requests SHALL be served in rotating order; no master served twice while another requests continuously.
REQ-025 Requests arriving during BUS/RELEASE SHALL wait; m_cyc_i is level, not latched.
REQ-026 busy_o SHALL equal (state==BUS); grant_o SHALL hold last owner in IDLE/RELEASE.

Reset
REQ-027 On rst: state IDLE, grant_o 0, last_owner 3 (so master 0 wins first), err_o 0, timeout counter 0.
REQ-028 rst in BUS SHALL abort the transaction next edge; no m_ack_o issued; all slave outputs 0 in the following cycle.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: 8-bit counter cleared on entering BUS, increments each BUS cycle without s_ack_i; when it equals TIMEOUT, SHALL pulse m_ack_o[owner] one cycle with m_dat_o=32'h0, set err_o, go to RELEASE.
REQ-030 ARB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for s_ack_i; err_o tied 0.

Verification
REQ-031 Reset then m_cyc_i=4'b0001 read adr 0x100, slave acks next cycle with 0x1234 -> m_ack_o=4'b0001 one cycle, m_dat_o=0x1234, grant_o=0.
REQ-032 m_cyc_i=4'b1111 held, slave acks each BUS cycle -> grant_o sequence 0,1,2,3,0.
REQ-033 Master 2 write adr 0x40 data 0xA5A5A5A5 -> s_we_o=1, s_adr_o=0x40, s_dat_o=0xA5A5A5A5 until ack; m_ack_o=4'b0100.
REQ-034 Master 1 drops m_cyc_i in BUS before ack -> state IDLE next cycle, no m_ack_o, next grant goes to master 2 if requesting.
REQ-035 rst asserted mid-BUS -> state IDLE, s_cyc_o=0, grant_o=0 after edge; no ack.
REQ-036 ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks -> m_ack_o[owner] pulses at 4th BUS cycle, m_dat_o=0, err_o=1 until rst.
